// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
//
// Executes MULT/MULTU/DIV/DIVU as multi-cycle operations and owns the HI/LO
// register pair. Also serves MFHI/MFLO (combinational read) and MTHI/MTLO
// (write at the clock edge).
//
// Optional feature (compile-time macro MDU_MADD_EN):
//   When defined, md_op codes 9..12 become MADD, MADDU, MSUB, MSUBU, which
//   accumulate a product into {HI,LO} with MULT latency. When undefined those
//   codes behave exactly like NONE.
//
// Parameters:
//   MULT_CYCLES  busy duration for MULT/MULTU (and MADD family), >= 1
//   DIV_CYCLES   busy duration for DIV/DIVU, >= 1
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous, active-high
//   md_op   in   4   E-stage op (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                    5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-12 MADD family)
//   A       in   32  forwarded rs value
//   B       in   32  forwarded rt value
//   req     in   1   exception/interrupt flush of the E-stage instruction
//   start   out  1   combinational issue strobe
//   busy    out  1   registered, high while an operation is in flight
//   HI      out  32  HI register
//   LO      out  32  LO register
//   MDOut   out  32  MFHI/MFLO read data, 0 otherwise
//
// Issue handshake: start is the "valid & ready" of a single-cycle issue. An op
// is accepted on the rising edge where start=1, i.e. a mult/div op is
// presented, the unit is idle (busy=0) and the instruction is not being
// flushed (req=0). There is no back-pressure signal beyond busy: the stall
// logic holds any HI/LO consumer in D while (start | busy), so exactly one op
// is ever accepted per busy window and ops presented while busy are dropped.
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    // -------------------------------------------------------------------------
    // Op encoding
    // -------------------------------------------------------------------------
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    // Counter is sized for the longer of the two latencies.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [31:0]      temp_hi;
    logic [31:0]      temp_lo;
    logic             nowrite;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic is_mult;      // MULT/MULTU and (optionally) the MADD family
    logic is_div;       // DIV/DIVU
    logic is_signed;    // signed flavour of the presented op
    logic is_md;

    always_comb begin
        is_mult   = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (md_op)
            OP_MULT:  begin is_mult = 1'b1; is_signed = 1'b1; end
            OP_MULTU: begin is_mult = 1'b1;                   end
            OP_DIV:   begin is_div  = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  begin is_div  = 1'b1;                   end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mult = 1'b1; is_signed = 1'b1; end
            OP_MADDU: begin is_mult = 1'b1;                   end
            OP_MSUB:  begin is_mult = 1'b1; is_signed = 1'b1; end
            OP_MSUBU: begin is_mult = 1'b1;                   end
`endif
            default:  ;
        endcase
    end

    assign is_md = is_mult | is_div;
    assign start = is_md & ~busy & ~req;

    // -------------------------------------------------------------------------
    // Multiplier: operands are extended to 64 bits explicitly so the product
    // is a plain 64-bit multiply in either signedness.
    // -------------------------------------------------------------------------
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    assign a_ext   = {{32{is_signed & A[31]}}, A};
    assign b_ext   = {{32{is_signed & B[31]}}, B};
    assign product = a_ext * b_ext;

    // -------------------------------------------------------------------------
    // Divider: signed division is done on magnitudes and the signs are patched
    // afterwards. This gives truncation toward zero, a remainder that takes the
    // dividend's sign, and makes 0x80000000 / -1 fall out naturally as
    // quotient 0x80000000, remainder 0. A zero divisor is replaced by 1 so the
    // datapath never divides by zero; the result is discarded via nowrite.
    // -------------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_neg    = is_signed & A[31];
    assign b_neg    = is_signed & B[31];
    assign div_zero = (B == 32'd0);
    assign a_mag    = a_neg ? (~A + 32'd1) : A;
    assign b_mag    = b_neg ? (~B + 32'd1) : B;
    assign den      = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / den;
    assign r_mag    = a_mag % den;
    assign quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

    // -------------------------------------------------------------------------
    // Result selection at issue
    // -------------------------------------------------------------------------
    logic [31:0]      next_hi;
    logic [31:0]      next_lo;
    logic [CNT_W-1:0] next_cnt;
    logic             next_nowrite;

`ifdef MDU_MADD_EN
    // Accumulate against the architectural {HI,LO}; 64-bit wrap-around.
    logic [63:0] acc_add;
    logic [63:0] acc_sub;

    assign acc_add = {HI, LO} + product;
    assign acc_sub = {HI, LO} - product;
`endif

    always_comb begin
        next_hi      = product[63:32];
        next_lo      = product[31:0];
        next_cnt     = MULT_LOAD;
        next_nowrite = 1'b0;
        if (is_div) begin
            next_hi      = rem;
            next_lo      = quot;
            next_cnt     = DIV_LOAD;
            next_nowrite = div_zero;
        end
`ifdef MDU_MADD_EN
        else if (md_op == OP_MADD || md_op == OP_MADDU) begin
            next_hi = acc_add[63:32];
            next_lo = acc_add[31:0];
        end
        else if (md_op == OP_MSUB || md_op == OP_MSUBU) begin
            next_hi = acc_sub[63:32];
            next_lo = acc_sub[31:0];
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Sequential state: issue, countdown, completion write-back, MTHI/MTLO.
    // The busy branch has priority, so a new op, MTHI or MTLO presented while
    // busy is ignored, and req cannot abort an op already in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= 32'd0;
            LO      <= 32'd0;
            busy    <= 1'b0;
            cnt     <= '0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            nowrite <= 1'b0;
        end else if (busy) begin
            if (cnt == CNT_ONE) begin
                if (!nowrite) begin
                    HI <= temp_hi;
                    LO <= temp_lo;
                end
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end else if (start) begin
            temp_hi <= next_hi;
            temp_lo <= next_lo;
            cnt     <= next_cnt;
            nowrite <= next_nowrite;
            busy    <= 1'b1;
        end else if (!req) begin
            if (md_op == OP_MTHI) begin
                HI <= A;
            end
            if (md_op == OP_MTLO) begin
                LO <= A;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read port
    // -------------------------------------------------------------------------
    always_comb begin
        MDOut = 32'd0;
        if (md_op == OP_MFHI) begin
            MDOut = HI;
        end else if (md_op == OP_MFLO) begin
            MDOut = LO;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- directed self-checking bench for md_unit.
//
// Inputs change 1 time unit after the rising edge; outputs are checked in the
// same low-activity window, well away from the next active edge. All expected
// values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd10;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MSUB  = 4'd11;
`endif

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .req   (req),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    // -------------------------------------------------------------------------
    // Checkers
    // -------------------------------------------------------------------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check32({tag, "_hi"}, HI, exp_hi);
        check32({tag, "_lo"}, LO, exp_lo);
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md_op = OP_NONE;
        A     = 32'd0;
        B     = 32'd0;
        req   = 1'b0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        md_op = op;
        A     = val;
        tick();
        idle_inputs();
    endtask

    // Issue an op, check the one-cycle start strobe, then check that busy is
    // high for exactly n cycles and drops afterwards.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n);
        md_op = op;
        A     = a;
        B     = b;
        #1;
        check1({tag, "_start"}, start, 1'b1);
        tick();
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            check1({tag, "_busy"}, busy, 1'b1);
            tick();
        end
        check1({tag, "_done"}, busy, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_start", start, 1'b0);
        check_hilo("rst", 32'h0, 32'h0);

        // MTHI then MFHI / MFLO
        move_to(OP_MTHI, 32'h1234_5678);
        check_hilo("mthi", 32'h1234_5678, 32'h0);
        md_op = OP_MFHI;
        #1;
        check32("mfhi", MDOut, 32'h1234_5678);
        md_op = OP_MFLO;
        #1;
        check32("mflo0", MDOut, 32'h0);
        md_op = OP_NONE;
        #1;
        check32("mdout_none", MDOut, 32'h0);

        // MULT -2 * 3 = -6
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, MULT_N);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        // DIV -7 / 2 = -3 rem -1
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIVU 7 / 0: busy runs, HI/LO untouched
        run_op("divu0", OP_DIVU, 32'd7, 32'd0, DIV_N);
        check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV 0x80000000 / -1 overflow case
        run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
        check_hilo("divovf", 32'h0, 32'h8000_0000);

        // DIVU 100 / 7 = 14 rem 2
        run_op("divu", OP_DIVU, 32'd100, 32'd7, DIV_N);
        check_hilo("divu", 32'd2, 32'd14);

        // DIV 7 / -2 = -3 rem 1 (remainder follows dividend)
        run_op("divneg", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_N);
        check_hilo("divneg", 32'd1, 32'hFFFF_FFFD);

        // MULT flushed in its issue cycle
        md_op = OP_MULT;
        A     = 32'd2;
        B     = 32'd2;
        req   = 1'b1;
        #1;
        check1("req_start", start, 1'b0);
        tick();
        idle_inputs();
        check1("req_busy", busy, 1'b0);
        tick();
        check_hilo("req", 32'd1, 32'hFFFF_FFFD);

        // MULT 5*6 with MTHI attempted in cycle 2 and req in cycle 3
        md_op = OP_MULT;
        A     = 32'd5;
        B     = 32'd6;
        tick();                             // issue edge
        idle_inputs();
        check1("mreq_c1", busy, 1'b1);
        tick();                             // cycle 2
        md_op = OP_MTHI;
        A     = 32'hDEAD_BEEF;
        #1;
        check1("mreq_nostart", start, 1'b0);
        tick();                             // cycle 3
        idle_inputs();
        check32("mthi_busy_hi", HI, 32'd1);
        req = 1'b1;
        tick();                             // cycle 4
        req = 1'b0;
        check1("mreq_c4", busy, 1'b1);
        tick();                             // cycle 5
        check1("mreq_c5", busy, 1'b1);
        tick();
        check1("mreq_done", busy, 1'b0);
        check_hilo("mreq", 32'd0, 32'd30);

        // MTLO flushed, then MTLO taken
        md_op = OP_MTLO;
        A     = 32'h0000_AAAA;
        req   = 1'b1;
        tick();
        idle_inputs();
        check32("mtlo_req", LO, 32'd30);
        move_to(OP_MTLO, 32'h55);
        check32("mtlo", LO, 32'h55);
        md_op = OP_MFLO;
        #1;
        check32("mflo", MDOut, 32'h55);

        // Unknown op: no side effects
        md_op = 4'd15;
        A     = 32'hDEAD_0001;
        B     = 32'd3;
        #1;
        check1("unk_start", start, 1'b0);
        check32("unk_mdout", MDOut, 32'h0);
        tick();
        idle_inputs();
        check1("unk_busy", busy, 1'b0);
        check_hilo("unk", 32'd0, 32'h55);

        // Reset in cycle 4 of a DIV aborts it
        move_to(OP_MTHI, 32'h77);
        md_op = OP_DIV;
        A     = 32'd100;
        B     = 32'd3;
        tick();                             // issue edge -> cycle 1
        idle_inputs();
        tick();                             // cycle 2
        tick();                             // cycle 3
        tick();                             // cycle 4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check1("rstmid_busy", busy, 1'b0);
        check_hilo("rstmid", 32'h0, 32'h0);
        for (int i = 0; i < DIV_N; i++) begin
            tick();
        end
        check_hilo("rstmid_late", 32'h0, 32'h0);
        run_op("mult34", OP_MULT, 32'd3, 32'd4, MULT_N);
        check_hilo("mult34", 32'h0, 32'd12);

        // MADDU 1*1 onto {0, 0xFFFFFFFF}
        move_to(OP_MTHI, 32'h0);
        move_to(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, MULT_N);
        check_hilo("maddu", 32'd1, 32'd0);
        // MSUB: 0x1_00000000 - 1*2 = 0x0_FFFFFFFE
        run_op("msub", OP_MSUB, 32'd1, 32'd2, MULT_N);
        check_hilo("msub", 32'd0, 32'hFFFF_FFFE);
`else
        md_op = OP_MADDU;
        A     = 32'd1;
        B     = 32'd1;
        #1;
        check1("maddu_off_start", start, 1'b0);
        tick();
        idle_inputs();
        check1("maddu_off_busy", busy, 1'b0);
        for (int i = 0; i < MULT_N; i++) begin
            tick();
        end
        check_hilo("maddu_off", 32'h0, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit (MDU) in the E stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Drives start and busy to the stall logic, which stalls any HI/LO-using instruction in D while (start | busy).

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- md_op  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-12 are reserved for the optional feature; others are treated as NONE.
- A  input  32  forwarded rs value (MF_rs_E).
- B  input  32  forwarded rt value (MF_rt_E).
- req  input  1  exception/interrupt flush of the E-stage instruction; suppresses any HI/LO side effect this cycle.
- start  output  1  combinational; (md_op ∈ {MULT, MULTU, DIV, DIVU}) & ~busy & ~req.
- busy  output  1  registered; high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDOut  output  32  combinational; HI when md_op = MFHI, LO when md_op = MFLO, else 0.

Behaviour:
- Reset: HI=0, LO=0, busy=0, internal counter=0, temp_hi/temp_lo=0.
- Issue (edge with start=1):
  - Compute the result into temp_hi/temp_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy<=1.
- Arithmetic:
  - MULT: {temp_hi,temp_lo} = $signed(A)*$signed(B), 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: temp_lo = signed quotient (truncate toward zero), temp_hi = signed remainder (sign follows dividend).
  - DIVU: unsigned quotient and remainder.
  - DIV/DIVU with B=0: busy sequence runs normally; HI/LO are NOT updated at completion (internal nowrite flag).
  - DIV of 0x80000000 by -1: LO=0x80000000, HI=0.
- Busy phase: counter decrements each edge. At the edge where counter==1:
  - HI<=temp_hi and LO<=temp_lo, unless nowrite is set.
  - busy<=0, counter<=0.
  - busy is therefore high for exactly N cycles after the issue edge.
  - The new HI/LO are visible in the first cycle busy=0.
- Stall window: start|busy is high for N+1 cycles.
- MTHI/MTLO: at the edge, HI<=A or LO<=A, only if ~busy & ~req. Ignored while busy (stall logic prevents this case).
- MFHI/MFLO: read HI/LO directly. The stall logic guarantees these never coincide with busy.
- req:
  - req=1 blocks start, MTHI and MTLO in the same cycle.
  - req during busy does NOT abort; the in-flight op belongs to an older committed instruction and completes.
- Simultaneous events:
  - A mult/div presented while busy is ignored (start=0); the pipeline is stalled anyway.
  - The completion edge and a new start in the same cycle cannot occur, because start requires ~busy.
- Reset mid-operation: aborts the op; all state returns to reset values on that edge.
- Unknown md_op: no state change, MDOut=0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds md_op 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
  - At issue: temp = {HI,LO} ± product (signed/unsigned product, 64-bit wrap-around).
  - Latency MULT_CYCLES.
  - These ops count as mult for start.
  - Completion writes {HI,LO} like MULT.
- Undefined: codes 9-12 behave as NONE (start=0, no state change).

Test Plan:
- Reset held 2 cycles, then MTHI A=0x12345678 → HI=0x12345678 next cycle; MFHI → MDOut=0x12345678; LO=0.
- MULT A=0xFFFFFFFE (-2), B=3 → start=1 for one cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x2, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 → busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → busy 10 cycles; HI/LO unchanged.
- MULT with req=1 in the issue cycle → start=0, busy stays 0, HI/LO unchanged. req=1 during cycle 3 of a busy MULT → op completes normally. MTLO with req=1 → LO unchanged.
- reset asserted in cycle 4 of a DIV → next cycle busy=0, HI=LO=0; a subsequent MULT 3×4 → LO=12 after 5 cycles.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0. Without the macro the same op → start=0, no change.
